// File: rtl/bram_scan_pkg.sv
// Shared types for the BRAM scan address generator.
// Scan modes, FSM states and the registered output beat.
package bram_scan_pkg;

  localparam int SCAN_MAX_W  = 120;
  localparam int SCAN_MAX_H  = 240;
  localparam int SCAN_ADDR_W = $clog2(SCAN_MAX_W * SCAN_MAX_H);

  typedef enum logic [1:0] {
    H_FWD = 2'd0,
    H_REV = 2'd1,
    V_FWD = 2'd2,
    V_REV = 2'd3
  } scan_dir_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  // Address field is sized from the package default geometry.
  typedef struct packed {
    logic [SCAN_ADDR_W-1:0] addr;
    logic                   line_first;
    logic                   line_last;
    logic                   frame_last;
  } addr_beat_t;

  // Vertical modes walk columns; horizontal modes walk rows.
  function automatic logic is_vert(scan_dir_e d);
    return d[1];
  endfunction

endpackage

// File: rtl/scan_rc_counter.sv
// Line-index / line-count tracker for the scan generator.
// Ports: load (restart at 0,0), step (one beat), vert, width, height;
// outputs current line count and decode of the next position.
module scan_rc_counter
  import bram_scan_pkg::*;
#(
  parameter  int MAX_WIDTH  = SCAN_MAX_W,
  parameter  int MAX_HEIGHT = SCAN_MAX_H,
  localparam int WW = $clog2(MAX_WIDTH + 1),
  localparam int HW = $clog2(MAX_HEIGHT + 1),
  localparam int CW = (WW > HW) ? WW : HW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic          vert,
  input  logic [WW-1:0] width,
  input  logic [HW-1:0] height,
  output logic [CW-1:0] line_cnt,
  output logic          nxt_first,
  output logic          nxt_last,
  output logic          nxt_frame_last
);

  logic [CW-1:0] idx_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] idx_d;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] len;
  logic [CW-1:0] lines;
  logic [CW-1:0] len_m1;
  logic [CW-1:0] lines_m1;

  // A line is a row in H modes and a column in V modes.
  assign len      = vert ? CW'(height) : CW'(width);
  assign lines    = vert ? CW'(width)  : CW'(height);
  assign len_m1   = len - CW'(1);
  assign lines_m1 = lines - CW'(1);

  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (load) begin
      idx_d = '0;
      cnt_d = '0;
    end else if (step) begin
      if (idx_q == len_m1) begin
        idx_d = '0;
        cnt_d = cnt_q + CW'(1);
      end else begin
        idx_d = idx_q + CW'(1);
      end
    end
  end

  // Flags describe the beat the top registers alongside idx_d/cnt_d.
  assign nxt_first      = (idx_d == '0);
  assign nxt_last       = (idx_d == len_m1);
  assign nxt_frame_last = nxt_last && (cnt_d == lines_m1);
  assign line_cnt       = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bram_scan_addr_gen.sv
// Runtime-configurable BRAM frame scan address generator.
// Ports: start/dir/cfg_*/frame_base in; addr beat with valid/ready,
// line/frame flags, busy, done pulse and cfg_err out.
module bram_scan_addr_gen
  import bram_scan_pkg::*;
#(
  parameter  int MAX_WIDTH  = SCAN_MAX_W,
  parameter  int MAX_HEIGHT = SCAN_MAX_H,
  parameter  int ADDR_W     = $clog2(MAX_WIDTH * MAX_HEIGHT),
  localparam int WW = $clog2(MAX_WIDTH + 1),
  localparam int HW = $clog2(MAX_HEIGHT + 1),
  localparam int CW = (WW > HW) ? WW : HW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        dir,
  input  logic [WW-1:0]     cfg_width,
  input  logic [HW-1:0]     cfg_height,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              line_first,
  output logic              line_last,
  output logic              frame_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [WW-1:0] W_MAX = WW'(MAX_WIDTH);
  localparam logic [HW-1:0] H_MAX = HW'(MAX_HEIGHT);

  scan_state_e       state_q;
  scan_dir_e         dir_q;
  logic [WW-1:0]     w_q;
  logic [HW-1:0]     h_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] off_q;
  addr_beat_t        beat_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              hs;
  logic              cfg_bad;
  logic              ld;
  logic              stp;
  logic [WW+HW-1:0]  prod;
  logic [ADDR_W-1:0] w_a;
  logic [ADDR_W-1:0] col1;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] addr_nx;
  logic [CW-1:0]     line_cnt;
  logic              nf;
  logic              nl;
  logic              nfl;

  assign hs  = valid_q & addr_ready;
  assign ld  = (state_q == SETUP);
  assign stp = (state_q == RUN) & hs;

  assign cfg_bad = (cfg_width == '0) || (cfg_height == '0) ||
                   (cfg_width > W_MAX) || (cfg_height > H_MAX);

  // Single multiplier, used only while in SETUP.
  assign prod = (WW+HW)'(h_q - HW'(1)) * (WW+HW)'(w_q);

  assign w_a  = ADDR_W'(w_q);
  assign col1 = ADDR_W'(line_cnt) + ADDR_W'(1);

  always_comb begin
    first_addr = base_q;
    unique case (dir_q)
      H_FWD: first_addr = base_q;
      H_REV: first_addr = base_q + w_a - ADDR_W'(1);
      V_FWD: first_addr = base_q;
      V_REV: first_addr = base_q + ADDR_W'(prod);
    endcase
  end

  // Incremental step; line ends jump to the start of the next line.
  always_comb begin
    addr_nx = beat_q.addr;
    unique case (dir_q)
      H_FWD: addr_nx = beat_q.addr + ADDR_W'(1);
      H_REV: addr_nx = beat_q.line_last
                     ? beat_q.addr + (w_a << 1) - ADDR_W'(1)
                     : beat_q.addr - ADDR_W'(1);
      V_FWD: addr_nx = beat_q.line_last
                     ? base_q + col1
                     : beat_q.addr + w_a;
      V_REV: addr_nx = beat_q.line_last
                     ? base_q + off_q + col1
                     : beat_q.addr - w_a;
    endcase
  end

  scan_rc_counter #(
    .MAX_WIDTH  (MAX_WIDTH),
    .MAX_HEIGHT (MAX_HEIGHT)
  ) u_rc (
    .clk            (clk),
    .reset          (reset),
    .load           (ld),
    .step           (stp),
    .vert           (is_vert(dir_q)),
    .width          (w_q),
    .height         (h_q),
    .line_cnt       (line_cnt),
    .nxt_first      (nf),
    .nxt_last       (nl),
    .nxt_frame_last (nfl)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= H_FWD;
      w_q     <= '0;
      h_q     <= '0;
      base_q  <= '0;
      off_q   <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            dir_q  <= scan_dir_e'(dir);
            w_q    <= cfg_width;
            h_q    <= cfg_height;
            base_q <= frame_base;
            err_q  <= cfg_bad;
            if (cfg_bad) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= SETUP;
            end
          end
        end
        SETUP: begin
          off_q   <= ADDR_W'(prod);
          beat_q  <= '{first_addr, nf, nl, nfl};
          valid_q <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          if (hs) begin
            if (beat_q.frame_last) begin
              beat_q  <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              beat_q <= '{addr_nx, nf, nl, nfl};
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign addr_valid = valid_q;
  assign addr       = beat_q.addr;
  assign line_first = beat_q.line_first;
  assign line_last  = beat_q.line_last;
  assign frame_last = beat_q.frame_last;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_bram_scan_addr_gen.sv
// Scoreboard bench for bram_scan_addr_gen.
// Expected beats come from direct row/column formulas per scan mode.
module tb_bram_scan_addr_gen;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    dir;
  logic [6:0]    cfg_width;
  logic [7:0]    cfg_height;
  logic [AW-1:0] frame_base;
  logic          addr_valid;
  logic          addr_ready;
  logic [AW-1:0] addr;
  logic          line_first;
  logic          line_last;
  logic          frame_last;
  logic          busy;
  logic          done;
  logic          cfg_err;

  typedef struct {
    int addr;
    bit lf;
    bit ll;
    bit fl;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   hs_count = 0;
  bit   rand_ready = 1'b0;

  bram_scan_addr_gen dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dir        (dir),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .frame_base (frame_base),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr       (addr),
    .line_first (line_first),
    .line_last  (line_last),
    .frame_last (frame_last),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    addr_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Row r, column c lives at base + r*width + c.
  task automatic push_frame(input int d, input int w, input int h,
                            input int b);
    int lines;
    int len;
    int r;
    int c;
    exp_t e;
    lines = (d >= 2) ? w : h;
    len   = (d >= 2) ? h : w;
    for (int ln = 0; ln < lines; ln++) begin
      for (int i = 0; i < len; i++) begin
        case (d)
          0:       begin r = ln;        c = i;         end
          1:       begin r = ln;        c = w - 1 - i; end
          2:       begin r = i;         c = ln;        end
          default: begin r = h - 1 - i; c = ln;        end
        endcase
        e.addr = (b + r * w + c) & 32'h7fff;
        e.lf   = (i == 0);
        e.ll   = (i == len - 1);
        e.fl   = (ln == lines - 1) && (i == len - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (addr_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat addr=%0d required=none", addr);
        end else begin
          chk("beat_addr", 32'(addr), 32'(exp_q[0].addr));
          chk("beat_flags", {29'd0, line_first, line_last, frame_last},
              {29'd0, exp_q[0].lf, exp_q[0].ll, exp_q[0].fl});
          if (addr_ready) begin
            void'(exp_q.pop_front());
            hs_count++;
          end
        end
      end else begin
        chk("idle_flags", {29'd0, line_first, line_last, frame_last}, 0);
      end
    end
  end

  task automatic do_scan(input int d, input int w, input int h,
                         input int b, input bit timed);
    bit bad;
    bit got;
    int n;
    int lim;
    bad = (w == 0) || (h == 0) || (w > 120) || (h > 240);
    if (!bad) push_frame(d, w, h, b);
    hs_count = 0;
    @(posedge clk);
    #1;
    dir        = 2'(d);
    cfg_width  = 7'(w);
    cfg_height = 8'(h);
    frame_base = AW'(b);
    start      = 1'b1;
    @(posedge clk);
    #1;
    n     = cyc;
    start = 1'b0;
    if (bad) begin
      chk("bad_done", 32'(done), 1);
      chk("bad_cfg_err", 32'(cfg_err), 1);
      chk("bad_busy", 32'(busy), 0);
      chk("bad_valid", 32'(addr_valid), 0);
      @(posedge clk);
      #1;
      chk("bad_done_drop", 32'(done), 0);
      chk("bad_err_hold", 32'(cfg_err), 1);
      return;
    end
    chk("busy_n1", 32'(busy), 1);
    chk("cfg_err_clear", 32'(cfg_err), 0);
    chk("valid_n1", 32'(addr_valid), 0);
    lim = w * h * 3 + 100;
    got = 1'b0;
    for (int k = 0; k < lim; k++) begin
      @(posedge clk);
      #1;
      if (timed && k == 0) chk("valid_n2", 32'(addr_valid), 1);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(got), 1);
    if (timed) chk("done_cycle", 32'(cyc - n), 32'(1 + w * h));
    chk("done_busy", 32'(busy), 0);
    chk("handshakes", 32'(hs_count), 32'(w * h));
    chk("queue_empty", 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(done), 0);
  endtask

  initial begin
    bit got;
    reset      = 1'b1;
    start      = 1'b0;
    dir        = 2'd0;
    cfg_width  = 7'd0;
    cfg_height = 8'd0;
    frame_base = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(addr_valid), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_flags", {29'd0, line_first, line_last, frame_last}, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    reset = 1'b0;

    do_scan(1, 4, 3, 100, 1);
    do_scan(2, 4, 3, 100, 1);
    do_scan(3, 4, 3, 100, 1);
    do_scan(0, 4, 3, 32760, 1);
    do_scan(0, 0, 3, 5, 1);
    do_scan(0, 121, 3, 5, 1);
    do_scan(0, 1, 1, 7, 1);
    do_scan(2, 4, 241, 0, 1);
    do_scan(3, 120, 2, 32000, 1);
    do_scan(1, 1, 5, 9, 1);

    rand_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      do_scan($urandom_range(0, 3), $urandom_range(1, 9),
              $urandom_range(1, 9), $urandom_range(0, 32767), 0);
    end
    do_scan(2, 120, 240, $urandom_range(0, 32767), 0);
    rand_ready = 1'b0;

    push_frame(0, 10, 5, 50);
    hs_count = 0;
    @(posedge clk);
    #1;
    dir        = 2'd0;
    cfg_width  = 7'd10;
    cfg_height = 8'd5;
    frame_base = AW'(50);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    got   = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (hs_count >= 5) begin
        got = 1'b1;
        break;
      end
    end
    chk("mid_beats_seen", 32'(got), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 32'(addr_valid), 0);
    chk("mid_rst_addr", 32'(addr), 0);
    chk("mid_rst_flags", {29'd0, line_first, line_last, frame_last}, 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_no_done", 32'(done), 0);
    reset = 1'b0;
    do_scan(0, 10, 5, 50, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
